// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encodings for the
// instruction fetch stage.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] HALT_OPCODE = 32'hFFFF_FFFF;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: advance, flush to bubble,
// synchronous reset.
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter int NB_PC    = 32,
  parameter int NB_INSTR = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  input  logic [NB_INSTR-1:0] d_instruction,
  input  logic [NB_PC-1:0]    d_pc_plus4,
  output logic [NB_INSTR-1:0] q_instruction,
  output logic [NB_PC-1:0]    q_pc_plus4,
  output logic                q_valid
);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      q_instruction <= NB_INSTR'(NOP);
      q_pc_plus4    <= '0;
      q_valid       <= 1'b0;
    end else if (enable) begin
      q_instruction <= d_instruction;
      q_pc_plus4    <= d_pc_plus4;
      q_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, next-PC mux, HALT detection FSM
// and the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                NB_PC        = 32,
  parameter int                NB_INSTR     = 32,
  parameter int                NB_IMEM_ADDR = 10,
  parameter logic [NB_PC-1:0]  RESET_PC     = '0,
  parameter logic [NB_INSTR-1:0] HALT_OPCODE =
    NB_INSTR'(instruction_fetch_pkg::HALT_OPCODE)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_hazard,
  input  logic                    i_jump,
  input  logic [NB_PC-1:0]        i_jump_target,
  input  logic                    i_branch_taken,
  input  logic [NB_PC-1:0]        i_branch_target,
  input  logic [NB_INSTR-1:0]     i_imem_data,
  output logic [NB_IMEM_ADDR-1:0] o_imem_addr,
  output logic [NB_INSTR-1:0]     o_instruction,
  output logic [NB_PC-1:0]        o_pc_plus4,
  output logic                    o_instr_valid,
  output logic [NB_PC-1:0]        o_pc,
  output logic                    o_halted
);

  if_state_t        state;
  if_state_t        state_next;
  logic [NB_PC-1:0] pc;
  logic [NB_PC-1:0] pc_next;
  logic [NB_PC-1:0] pc_plus4;
  logic             advance;
  logic             flush;

  assign pc_plus4 = pc + NB_PC'(PC_STEP);

  always_comb begin
    pc_next    = pc;
    state_next = state;
    advance    = 1'b0;
    flush      = 1'b0;
    if (i_valid) begin
      unique case (state)
        RUN: begin
          if (i_hazard) begin
            // ID is stalled, so its redirect is not final yet
          end else if (i_jump) begin
            pc_next = i_jump_target;
            flush   = 1'b1;
          end else if (i_branch_taken) begin
            pc_next = i_branch_target;
            flush   = 1'b1;
          end else if (i_imem_data == HALT_OPCODE) begin
            advance    = 1'b1;
            state_next = HALTED;
          end else begin
            advance = 1'b1;
            pc_next = pc_plus4;
          end
        end
        HALTED: flush = 1'b1;
        default: flush = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  if_id_register #(
    .NB_PC    (NB_PC),
    .NB_INSTR (NB_INSTR)
  ) u_if_id (
    .clock         (i_clock),
    .reset         (i_reset),
    .enable        (advance),
    .flush         (flush),
    .d_instruction (i_imem_data),
    .d_pc_plus4    (pc_plus4),
    .q_instruction (o_instruction),
    .q_pc_plus4    (o_pc_plus4),
    .q_valid       (o_instr_valid)
  );

  assign o_imem_addr = pc[NB_IMEM_ADDR+1:2];
  assign o_pc        = pc;
  assign o_halted    = (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed
// cycles push expectations, a monitor pops and checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic        haz;
  logic        jmp;
  logic [31:0] jt;
  logic        br;
  logic [31:0] bt;
  logic [31:0] imem_data;
  logic [9:0]  imem_addr;
  logic [31:0] instr;
  logic [31:0] p4;
  logic        iv;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] mem [0:1023];

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        v;
    logic        h;
    logic        cp4;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  instruction_fetch dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_valid         (vld),
    .i_hazard        (haz),
    .i_jump          (jmp),
    .i_jump_target   (jt),
    .i_branch_taken  (br),
    .i_branch_target (bt),
    .i_imem_data     (imem_data),
    .o_imem_addr     (imem_addr),
    .o_instruction   (instr),
    .o_pc_plus4      (p4),
    .o_instr_valid   (iv),
    .o_pc            (pc),
    .o_halted        (halted)
  );

  task automatic chk(input string n, input string f,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h",
               n, f, act, exp);
    end
  endtask

  // monitor: DUT outputs settle one step after the edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [31:0] ea;
      e  = q.pop_front();
      ea = {22'd0, e.pc[11:2]};
      chk(e.name, "pc", pc, e.pc);
      chk(e.name, "imem_addr", {22'd0, imem_addr}, ea);
      chk(e.name, "instr", instr, e.instr);
      chk(e.name, "valid", {31'd0, iv}, {31'd0, e.v});
      chk(e.name, "halted", {31'd0, halted}, {31'd0, e.h});
      if (e.cp4) chk(e.name, "pc_plus4", p4, e.p4);
    end
  end

  task automatic cyc(
    input string n,
    input logic r, input logic v, input logic h,
    input logic j, input logic [31:0] jtv,
    input logic b, input logic [31:0] btv,
    input logic [31:0] epc, input logic [31:0] ein,
    input logic [31:0] ep4, input logic ev,
    input logic eh, input logic cp4);
    exp_t e;
    @(negedge clk);
    rst = r; vld = v; haz = h;
    jmp = j; jt = jtv; br = b; bt = btv;
    e.name = n; e.pc = epc; e.instr = ein; e.p4 = ep4;
    e.v = ev; e.h = eh; e.cp4 = cp4;
    q.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h2001_0005;
    mem[1]    = 32'h2002_0007;
    mem[2]    = 32'h0022_1820;
    mem[4]    = 32'hFFFF_FFFF;
    mem[16]   = 32'h1234_5678;
    mem[32]   = 32'hAAAA_0001;
    mem[1023] = 32'h0BAD_0001;
    rst = 1'b1; vld = 1'b0; haz = 1'b0;
    jmp = 1'b0; jt = '0; br = 1'b0; bt = '0;

    //    name      r v h j jt           b bt      pc           instr        p4      v h cp4
    cyc("reset",   1,0,0,0,0,          0,0,      0,           0,           0,      0,0,1);
    cyc("fetch0",  0,1,0,0,0,          0,0,      4,           32'h20010005,4,      1,0,1);
    cyc("fetch1",  0,1,0,0,0,          0,0,      8,           32'h20020007,8,      1,0,1);
    cyc("stall1",  0,1,1,0,0,          0,0,      8,           32'h20020007,8,      1,0,1);
    cyc("stall2",  0,1,1,1,32'h100,    1,32'h40, 8,           32'h20020007,8,      1,0,1);
    cyc("fetch2",  0,1,0,0,0,          0,0,      12,          32'h00221820,12,     1,0,1);
    cyc("fetch3",  0,1,0,0,0,          0,0,      16,          32'h0,       16,     1,0,1);
    cyc("branch",  0,1,0,0,0,          1,32'h40, 32'h40,      32'h0,       0,      0,0,0);
    cyc("tgtfet",  0,1,0,0,0,          0,0,      32'h44,      32'h12345678,32'h44, 1,0,1);
    cyc("jmpbr",   0,1,0,1,32'h80,     1,32'h40, 32'h80,      32'h0,       0,      0,0,0);
    cyc("jbhaz",   0,1,1,1,32'h200,    1,32'h40, 32'h80,      32'h0,       0,      0,0,0);
    cyc("fetch20", 0,1,0,0,0,          0,0,      32'h84,      32'hAAAA0001,32'h84, 1,0,1);
    for (int i = 0; i < 5; i++)
      cyc("frozen", 0,0,i[0],~i[0],32'h200,i[1],32'h300,
          32'h84, 32'hAAAA0001, 32'h84, 1,0,1);
    cyc("jmptop",  0,1,0,1,32'hFFFFFFFC,0,0,  32'hFFFFFFFC,32'h0,       0,      0,0,0);
    cyc("wrap",    0,1,0,0,0,          0,0,      0,           32'h0BAD0001,0,      1,0,1);
    cyc("jmp10",   0,1,0,1,32'h10,     0,0,      32'h10,      32'h0,       0,      0,0,0);
    cyc("halt",    0,1,0,0,0,          0,0,      16,          32'hFFFFFFFF,20,     1,1,1);
    cyc("hlt_idl", 0,1,0,0,0,          0,0,      16,          32'h0,       0,      0,1,0);
    cyc("hlt_red", 0,1,1,1,32'h80,     1,32'h40, 16,          32'h0,       0,      0,1,0);
    cyc("hlt_frz", 0,0,0,1,32'h80,     0,0,      16,          32'h0,       0,      0,1,0);
    cyc("hlt_rst", 1,1,0,0,0,          0,0,      0,           32'h0,       0,      0,0,1);
    cyc("restart", 0,1,0,0,0,          0,0,      4,           32'h20010005,4,      1,0,1);
    cyc("rststl",  1,1,1,0,0,          0,0,      0,           32'h0,       0,      0,0,1);

    for (int k = 0; k < 20 && q.size() > 0; k++)
      @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage of the 5-stage MIPS pipeline. Owns the PC and the IF/ID pipeline register, and reads instruction memory.
Consumes the hazard unit's stall line and the ID-stage branch/jump redirect. Feeds instruction, PC+4 and a valid flag to ID.
Detects the HALT instruction, stops fetching, and reports halted status to the debug unit.

Parameters:
NB_PC, 32, PC width in bits
NB_INSTR, 32, instruction width
NB_IMEM_ADDR, 10, instruction memory word-address width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 32'hFFFFFFFF, instruction encoding that stops fetch

Ports:
i_clock  in  1  clock, posedge
i_reset  in  1  reset
i_valid  in  1  global step enable from debug unit; 0 freezes all state
i_hazard  in  1  stall request from hazard unit (load-use or branch-operand hazard)
i_jump  in  1  ID resolved jump
i_jump_target  in  NB_PC  jump destination
i_branch_taken  in  1  ID resolved taken branch
i_branch_target  in  NB_PC  branch destination
i_imem_data  in  NB_INSTR  instruction memory read data, combinational w.r.t. o_imem_addr
o_imem_addr  out  NB_IMEM_ADDR  word address, equals pc[NB_IMEM_ADDR+1:2]
o_instruction  out  NB_INSTR  IF/ID instruction
o_pc_plus4  out  NB_PC  IF/ID PC+4 of that instruction
o_instr_valid  out  1  IF/ID holds a real instruction (0 = bubble)
o_pc  out  NB_PC  current fetch PC (debug)
o_halted  out  1  fetch stopped on HALT

Behaviour:
- Reset: i_reset is synchronous, active-high, and has priority over i_valid.
  - Reset values: pc=RESET_PC, o_instruction=0 (NOP), o_pc_plus4=0, o_instr_valid=0, state=RUN, o_halted=0.
- FSM has two states: RUN and HALTED. Exit from HALTED is by reset only.
- i_valid=0: PC, IF/ID register and FSM hold, regardless of the other inputs.
- Priority in RUN when i_valid=1: hazard > jump > branch > halt detect > normal.
- Hazard (i_hazard=1):
  - PC and IF/ID hold.
  - Redirect inputs are ignored, because the instruction in ID is stalled and its resolution is not final.
- Jump (i_jump=1, no hazard): pc<=i_jump_target; IF/ID <= NOP with valid=0. This flushes the wrong-path fetch; there is no delay slot.
- Branch (i_branch_taken=1, no hazard, no jump): pc<=i_branch_target; IF/ID flushed as for jump.
- Both i_jump and i_branch_taken high: jump wins.
- Halt (i_imem_data==HALT_OPCODE, none of the above):
  - IF/ID <= {HALT, pc+4}, valid=1. pc holds. State goes to HALTED.
  - A HALT fetched in the same cycle as a redirect is squashed, and state stays RUN.
- Normal fetch: IF/ID <= {i_imem_data, pc+4}, valid=1; pc<=pc+4.
- HALTED with i_valid=1:
  - pc holds; IF/ID <= NOP, valid=0, each cycle.
  - o_halted=1; i_hazard and redirects are ignored.
- Output latency: o_instruction, o_pc_plus4 and o_instr_valid are registered, one cycle after fetch. o_imem_addr, o_pc and o_halted come directly from registers.
- Arithmetic: pc+4 wraps modulo 2^NB_PC with no overflow flag. Targets are used as given; pc[1:0] is not checked.
- Reset asserted mid-stall or while HALTED: the next cycle is the reset state, and fetch restarts at RESET_PC.

Decomposition:
- Shared package/include holds: NOP encoding (0), HALT_OPCODE, PC_STEP=4, and the RUN/HALTED state encodings.
- Sub-module if_id_register: a parameterised register with enable (advance), flush (load NOP, valid=0) and synchronous reset.
  - Its flush input has priority over its enable input.
- PC next-value mux and FSM stay in instruction_fetch.

Test Plan:
- Reset then 3 enabled cycles, memory returns 0x20010005, 0x20020007, 0x00221820 at words 0,1,2:
  - o_imem_addr steps 0,1,2,3.
  - o_pc_plus4 steps 4,8,12, with matching instructions and valid=1.
- i_hazard=1 for 2 cycles while pc=8: pc stays 8 and IF/ID holds {0x20020007, 8}. On the cycle after release, fetch resumes from word 2.
- i_branch_taken=1, target 0x40, at pc=0x10: next pc=0x40 and IF/ID valid=0 (NOP). The following cycle fetches word 0x10.
- i_jump=1 (target 0x80) and i_branch_taken=1 (target 0x40) together: pc=0x80. The same pair asserted together with i_hazard=1: pc unchanged.
- HALT at word 4: IF/ID gets {0xFFFFFFFF, 20}, valid=1, and o_halted=1.
  - Afterwards pc stays 16 and IF/ID shows NOP with valid=0.
  - i_reset returns pc to 0 and o_halted to 0.
- i_valid=0 for 5 cycles, with hazard/redirect toggling: all outputs constant. pc=0xFFFFFFFC with a normal fetch: pc wraps to 0.
